// File: rtl/vga_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_renderer
//  Description : Places an IMG_W x IMG_H image, upscaled by SCALE, at screen
//                offset (X0, Y0). Addresses are generated incrementally (no
//                multiplier). hsync, vsync and rgb are delayed by the same
//                LAT = MEM_LAT+2 cycles so that all three stay aligned.
//  Optional    : `define VGA_RENDER_BORDER_EN adds a 1-pixel BORDER_COLOR
//                frame around the image window.
//  Ports       : clk, rst_n (async, active-low)
//                in_hsync/in_vsync/in_x/in_y/in_video_on/frame_start : timing in
//                mem_addr/mem_rd_en -> memory, mem_data <- memory
//                hsync/vsync/rgb : aligned video out
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_renderer #(
    parameter int               IMG_W        = 320,
    parameter int               IMG_H        = 240,
    parameter int               SCALE        = 2,
    parameter int               X0           = 0,
    parameter int               Y0           = 0,
    parameter int               PIX_W        = 3,
    parameter int               MEM_LAT      = 1,
    parameter logic [PIX_W-1:0] BG_COLOR     = '0,
`ifdef VGA_RENDER_BORDER_EN
    parameter logic [PIX_W-1:0] BORDER_COLOR = {PIX_W{1'b1}},
`endif
    parameter int               ADDR_W       = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    input  logic              in_video_on,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [PIX_W-1:0]  mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic [PIX_W-1:0]  rgb
);

    localparam int c_LAT    = MEM_LAT + 2;
    localparam int c_XE_RAW = X0 + IMG_W*SCALE;
    localparam int c_YE_RAW = Y0 + IMG_H*SCALE;
    // Window bounds clipped to the 640x480 visible area
    localparam int c_XE     = (c_XE_RAW > 640) ? 640 : c_XE_RAW;
    localparam int c_YE     = (c_YE_RAW > 480) ? 480 : c_YE_RAW;

    // Signed 12-bit coordinates keep the X0-1 / Y0-1 comparisons well defined
    localparam logic signed [11:0] c_X0_S = 12'(X0);
    localparam logic signed [11:0] c_XE_S = 12'(c_XE);
    localparam logic signed [11:0] c_XL_S = 12'(c_XE - 1);
    localparam logic signed [11:0] c_Y0_S = 12'(Y0);
    localparam logic signed [11:0] c_YE_S = 12'(c_YE);

    localparam logic [1:0]        c_SMAX = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(IMG_W);

    logic signed [11:0] w_xs;
    logic signed [11:0] w_ys;
    logic               w_in_win;
    logic               w_first;
    logic               w_last;

    assign w_xs     = {2'b00, in_x};
    assign w_ys     = {2'b00, in_y};
    assign w_in_win = in_video_on && (w_xs >= c_X0_S) && (w_xs < c_XE_S)
                                  && (w_ys >= c_Y0_S) && (w_ys < c_YE_S);
    assign w_first  = (w_xs == c_X0_S);
    assign w_last   = (w_xs == c_XL_S);

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col_addr;
    logic [1:0]        r_line_rep;
    logic [1:0]        r_sub_x;

    logic [ADDR_W-1:0] w_row_cur;
    logic [1:0]        w_rep_cur;
    logic [ADDR_W-1:0] w_col_next;
    logic [1:0]        w_sub_next;

    // frame_start clears take effect in the same cycle, so a window pixel
    // coinciding with frame_start already sees row_base = 0.
    assign w_row_cur = frame_start ? '0 : r_row_base;
    assign w_rep_cur = frame_start ? '0 : r_line_rep;

    always_comb begin
        w_col_next = r_col_addr;
        w_sub_next = r_sub_x;
        if (w_first) begin
            w_col_next = w_row_cur;
            w_sub_next = 2'd0;
        end else if (r_sub_x == c_SMAX) begin
            w_sub_next = 2'd0;
            w_col_next = r_col_addr + ADDR_W'(1);
        end else begin
            w_sub_next = r_sub_x + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_base <= '0;
            r_col_addr <= '0;
            r_line_rep <= 2'd0;
            r_sub_x    <= 2'd0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
        end else begin
            if (frame_start) begin
                r_row_base <= '0;
                r_line_rep <= 2'd0;
            end
            if (w_in_win) begin
                r_col_addr <= w_col_next;
                r_sub_x    <= w_sub_next;
                mem_addr   <= w_col_next;
                if (w_last) begin
                    // Replay the same source row SCALE times, then advance
                    if (w_rep_cur == c_SMAX) begin
                        r_line_rep <= 2'd0;
                        r_row_base <= w_row_cur + c_ROW_STEP;
                    end else begin
                        r_line_rep <= w_rep_cur + 2'd1;
                    end
                end
            end
            mem_rd_en <= w_in_win;
        end
    end

    // ------------------------------------------------------------------
    // Alignment pipeline
    // Syncs travel LAT stages to the outputs; window/video flags travel
    // LAT-1 stages so they sit beside mem_data when rgb is registered.
    // ------------------------------------------------------------------
    logic [c_LAT-1:0] r_hs_sr;
    logic [c_LAT-1:0] r_vs_sr;
    logic [c_LAT-2:0] r_win_sr;
    logic [c_LAT-2:0] r_vo_sr;

`ifdef VGA_RENDER_BORDER_EN
    localparam logic signed [11:0] c_BXL_S = 12'(X0 - 1);
    localparam logic signed [11:0] c_BXH_S = 12'(c_XE_RAW);
    localparam logic signed [11:0] c_BYL_S = 12'(Y0 - 1);
    localparam logic signed [11:0] c_BYH_S = 12'(c_YE_RAW);

    logic             w_border;
    logic [c_LAT-2:0] r_bdr_sr;

    // Inside the rectangle grown by one pixel but outside the window is
    // exactly the 1-pixel ring; in_video_on clips it to the visible area.
    assign w_border = in_video_on && !w_in_win
                      && (w_xs >= c_BXL_S) && (w_xs <= c_BXH_S)
                      && (w_ys >= c_BYL_S) && (w_ys <= c_BYH_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bdr_sr <= '0;
        end else begin
            r_bdr_sr <= {r_bdr_sr[c_LAT-3:0], w_border};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_sr  <= '1;
            r_vs_sr  <= '1;
            r_win_sr <= '0;
            r_vo_sr  <= '0;
            rgb      <= '0;
        end else begin
            r_hs_sr  <= {r_hs_sr[c_LAT-2:0], in_hsync};
            r_vs_sr  <= {r_vs_sr[c_LAT-2:0], in_vsync};
            r_win_sr <= {r_win_sr[c_LAT-3:0], w_in_win};
            r_vo_sr  <= {r_vo_sr[c_LAT-3:0], in_video_on};
            if (r_win_sr[c_LAT-2]) begin
                rgb <= mem_data;
`ifdef VGA_RENDER_BORDER_EN
            end else if (r_bdr_sr[c_LAT-2]) begin
                rgb <= BORDER_COLOR;
`endif
            end else if (r_vo_sr[c_LAT-2]) begin
                rgb <= BG_COLOR;
            end else begin
                rgb <= '0;
            end
        end
    end

    assign hsync = r_hs_sr[c_LAT-1];
    assign vsync = r_vs_sr[c_LAT-1];

endmodule
`default_nettype wire
